// File: rtl/shiftreg_univ.sv
// Universal SIZE-bit shift/rotate register with an automatic Start/Busy/Done serial transfer sequencer.
// Optional registered Parity output enabled by defining SHIFTREG_PARITY_EN.
module shiftreg_univ #(
    parameter  int SIZE  = 8,
    localparam int CNT_W = $clog2(SIZE + 1)
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Load,
    input  logic            En,
    input  logic            Start,
    input  logic [1:0]      Mode,
    input  logic            SerIn,
    input  logic [SIZE-1:0] DataIn,
    output logic            SerOut,
    output logic [SIZE-1:0] DataOut,
    output logic            Busy,
    output logic            Done
`ifdef SHIFTREG_PARITY_EN
   ,output logic            Parity
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SIZE-1:0]  r_reg;
    logic [SIZE-1:0]  w_reg_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_mode;
    logic [1:0]       w_mode_nxt;
    logic             w_out_sel;

    function automatic logic [SIZE-1:0] f_step(input logic [SIZE-1:0] v,
                                               input logic [1:0]      m,
                                               input logic            s);
        case (m)
            2'b00:   f_step = {v[SIZE-2:0], s};
            2'b01:   f_step = {s, v[SIZE-1:1]};
            2'b10:   f_step = {v[SIZE-2:0], v[SIZE-1]};
            default: f_step = {v[0], v[SIZE-1:1]};
        endcase
    endfunction

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_reg_nxt   = r_reg;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        case (r_state)
            S_IDLE: begin
                if (Load) begin
                    w_reg_nxt = DataIn;
                end else if (Start) begin
                    w_reg_nxt   = DataIn;
                    w_mode_nxt  = Mode;
                    w_cnt_nxt   = CNT_W'(SIZE);
                    w_state_nxt = S_SHIFT;
                end else if (En) begin
                    w_reg_nxt = f_step(r_reg, Mode, SerIn);
                end
            end
            S_SHIFT: begin
                if (Load) begin
                    w_reg_nxt   = DataIn;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_reg_nxt = f_step(r_reg, r_mode, SerIn);
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            // The exchanged word is held for the single Done cycle; all requests are dropped.
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
            r_reg   <= '0;
            r_cnt   <= '0;
            r_mode  <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_reg   <= w_reg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

`ifdef SHIFTREG_PARITY_EN
    logic r_parity;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= ^w_reg_nxt;
        end
    end

    assign Parity = r_parity;
`endif

    // A transfer in flight keeps the output tap it started with.
    assign w_out_sel = (r_state == S_SHIFT) ? r_mode[0] : Mode[0];
    assign SerOut    = w_out_sel ? r_reg[0] : r_reg[SIZE-1];
    assign DataOut   = r_reg;
    assign Busy      = (r_state == S_SHIFT);
    assign Done      = (r_state == S_DONE);

endmodule

// File: tb/tb_shiftreg_univ.sv
// Scoreboarded bench for shiftreg_univ: a driver pushes per-cycle expectations from an arithmetic
// reference model, and a separate negedge monitor pops and compares them against the DUT.
module tb_shiftreg_univ;

    localparam int          SIZE = 8;
    localparam logic [31:0] MASK = 32'((64'd1 << SIZE) - 1);

    logic            Clk = 1'b0;
    logic            Rst = 1'b1;
    logic            Load = 1'b0;
    logic            En = 1'b0;
    logic            Start = 1'b0;
    logic [1:0]      Mode = 2'b00;
    logic            SerIn = 1'b0;
    logic [SIZE-1:0] DataIn = '0;
    logic            SerOut;
    logic [SIZE-1:0] DataOut;
    logic            Busy;
    logic            Done;
`ifdef SHIFTREG_PARITY_EN
    logic            Parity;
`endif

    shiftreg_univ #(.SIZE(SIZE)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Load   (Load),
        .En     (En),
        .Start  (Start),
        .Mode   (Mode),
        .SerIn  (SerIn),
        .DataIn (DataIn),
        .SerOut (SerOut),
        .DataOut(DataOut),
        .Busy   (Busy),
        .Done   (Done)
`ifdef SHIFTREG_PARITY_EN
       ,.Parity (Parity)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [SIZE-1:0] dout;
        logic            busy;
        logic            done;
        logic            use_latched;
        logic            latched_bit;
    } exp_t;

    exp_t            exp_q[$];
    logic [SIZE-1:0] done_q[$];
    int              n_cmp = 0;
    int              n_bad = 0;

    // Reference model: the register as an integer, plus how many transfer steps remain.
    logic [31:0] m_reg   = 32'd0;
    int          m_left  = 0;
    bit          m_done  = 1'b0;
    logic [1:0]  m_mode  = 2'b00;

    function automatic logic [31:0] ref_step(input logic [31:0] r, input logic [1:0] md, input logic s);
        case (md)
            2'd0:    return ((r << 1) | 32'(s)) & MASK;
            2'd1:    return (r >> 1) | (32'(s) << (SIZE - 1));
            2'd2:    return ((r << 1) | (r >> (SIZE - 1))) & MASK;
            default: return (r >> 1) | ((r & 32'd1) << (SIZE - 1));
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Applies one cycle of inputs, advances the model across the edge and queues the expectation.
    task automatic cycle(input logic ld, input logic en, input logic st, input logic [1:0] md,
                         input logic si, input logic [SIZE-1:0] din, input logic rst);
        exp_t e;
        Load = ld; En = en; Start = st; Mode = md; SerIn = si; DataIn = din; Rst = rst;
        @(posedge Clk);
        if (rst) begin
            m_reg = 32'd0; m_left = 0; m_done = 1'b0;
        end else if (m_left > 0) begin
            if (ld) begin
                m_reg  = 32'(din);
                m_left = 0;
            end else begin
                m_reg  = ref_step(m_reg, m_mode, si);
                m_left = m_left - 1;
                if (m_left == 0) m_done = 1'b1;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (ld) begin
            m_reg = 32'(din);
        end else if (st) begin
            m_reg  = 32'(din);
            m_mode = md;
            m_left = SIZE;
        end else if (en) begin
            m_reg = ref_step(m_reg, md, si);
        end
        e.dout        = m_reg[SIZE-1:0];
        e.busy        = (m_left > 0);
        e.done        = m_done;
        e.use_latched = (m_left > 0);
        e.latched_bit = m_mode[0];
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, Mode, 1'b0, DataIn, 1'b0);
    endtask

    // Runs one automatic transfer; bits holds the SerIn values MSB-first, one per step edge.
    task automatic transfer(input logic [SIZE-1:0] din, input logic [1:0] md, input logic [SIZE-1:0] bits,
                            input int abort_at, input logic [SIZE-1:0] abort_word,
                            input bit busy_start, input bit done_start);
        logic [SIZE-1:0] want;
        if (md[1]) begin
            want = din;
        end else if (md[0] == 1'b0) begin
            want = bits;
        end else begin
            for (int j = 0; j < SIZE; j++) want[j] = bits[SIZE-1-j];
        end
        if (abort_at < 1) done_q.push_back(want);
        cycle(1'b0, 1'b0, 1'b1, md, 1'b0, din, 1'b0);
        for (int k = 1; k <= SIZE; k++) begin
            if (k == abort_at) begin
                cycle(1'b1, 1'b0, 1'b0, md, bits[SIZE-k], abort_word, 1'b0);
                check("abort_data", DataOut, abort_word);
                check("abort_busy", Busy, 1'b0);
                idle(SIZE + 2);
                return;
            end
            cycle(1'b0, 1'($urandom_range(0, 1)), (busy_start && k == 3), 2'($urandom_range(0, 3)),
                  bits[SIZE-k], SIZE'($urandom), 1'b0);
        end
        check("done_latency", Done, 1'b1);
        check("done_word", DataOut, want);
        cycle(1'b0, 1'b0, done_start, md, 1'b0, SIZE'($urandom), 1'b0);
        check("done_cleared", Done, 1'b0);
        idle(1);
    endtask

    // Monitor: pops one expectation per cycle and checks every output field.
    initial begin
        exp_t e;
        logic exp_ser;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dataout", DataOut, e.dout);
                check("busy", Busy, e.busy);
                check("done", Done, e.done);
                exp_ser = (e.use_latched ? e.latched_bit : Mode[0]) ? e.dout[0] : e.dout[SIZE-1];
                check("serout", SerOut, exp_ser);
`ifdef SHIFTREG_PARITY_EN
                check("parity", Parity, ^e.dout);
`endif
                if (Done === 1'b1) begin
                    if (done_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL done_unexpected: got Done=1, want no completed transfer (t=%0t)", $time);
                    end else begin
                        check("sb_done_word", DataOut, done_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of run, want finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int wait_cnt;
        cycle(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0, 1'b1);

        // Random manual activity, then a 3-cycle reset.
        for (int i = 0; i < 10; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), SIZE'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0, 1'b1);
        check("rst_dataout", DataOut, 8'h00);
        check("rst_serout", SerOut, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_done", Done, 1'b0);

        // Load then one manual shift-left step.
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'hAA, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 8'h00, 1'b0);
        check("man_shift", DataOut, 8'h55);
        check("man_serout", SerOut, 1'b0);

        // Directed transfers, abort, Start while busy and Start during Done.
        transfer(8'hAA, 2'b00, 8'b1011_0010, 0, '0, 1'b0, 1'b0);
        check("xfer_sl_result", DataOut, 8'hB2);
        transfer(8'h81, 2'b11, 8'b1010_1010, 0, '0, 1'b0, 1'b0);
        check("xfer_rr_result", DataOut, 8'h81);
        transfer(8'hF0, 2'b00, 8'b0110_0101, 3, 8'h3C, 1'b0, 1'b0);
        check("abort_hold", DataOut, 8'h3C);
        transfer(8'h5A, 2'b01, 8'b1100_1001, 0, '0, 1'b1, 1'b1);
        check("busy_start_result", DataOut, 8'h93);

`ifdef SHIFTREG_PARITY_EN
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h07, 1'b0);
        check("parity_07", Parity, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h03, 1'b0);
        check("parity_03", Parity, 1'b0);
`endif

        // Random mix of manual traffic and transfers (some aborted, some with ignored Starts).
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < int'($urandom_range(0, 3)); i++)
                cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'b0, 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), SIZE'($urandom), 1'b0);
            transfer(SIZE'($urandom), 2'($urandom_range(0, 3)), SIZE'($urandom),
                     ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, SIZE)) : 0,
                     SIZE'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a transfer: no Done may follow.
        cycle(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 8'hC3, 1'b0);
        idle(4);
        cycle(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 8'h00, 1'b1);
        check("midrst_busy", Busy, 1'b0);
        idle(SIZE + 2);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(negedge Clk);
            wait_cnt++;
        end
        #2;
        check("sb_drained", exp_q.size(), 0);
        check("sb_done_left", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
